// File: rtl/router_pkg.sv
// Types and constants shared by the 1-to-4 packet router and its ingress FIFO.
package router_pkg;

   localparam int ROUTER_DATA_W    = 8;
   localparam int ROUTER_ADDR_W    = 2;
   localparam int ROUTER_NUM_PORTS = 4;

   typedef struct packed {
      logic [ROUTER_ADDR_W-1:0] dest;
      logic [ROUTER_DATA_W-1:0] data;
   } router_entry_t;

endpackage

// File: rtl/router_ingress_mem.sv
// Ingress FIFO storage: synchronous write port, asynchronous read port, no reset.
module router_ingress_mem #(
   parameter int DEPTH = 8,
   parameter int W     = 10
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);

   logic [W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/router_ingress_fifo.sv
// First-word-fall-through buffer between the packet source and the router.
// src_ready depends only on registered occupancy, so a full FIFO never pushes and pops together.
module router_ingress_fifo
   import router_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = ROUTER_DATA_W,
   parameter int ADDR_W = ROUTER_ADDR_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       src_valid,
   input  logic [DATA_W-1:0]          src_data,
   input  logic [ADDR_W-1:0]          src_dest,
   output logic                       src_ready,
   output logic                       pkt_valid,
   output logic [DATA_W-1:0]          data_in,
   output logic [ADDR_W-1:0]          dest_addr,
   input  logic                       ready_in,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic                     push, pop;
   logic [ADDR_W+DATA_W-1:0] rd_entry;

   assign full      = (count_q == CNT_W'(DEPTH));
   assign empty     = (count_q == '0);
   assign src_ready = !full;
   assign pkt_valid = !empty;
   assign push      = src_valid && src_ready;
   assign pop       = pkt_valid && ready_in;
   assign count     = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   router_ingress_mem #(
      .DEPTH (DEPTH),
      .W     (ADDR_W + DATA_W)
   ) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr_q),
      .wdata ({src_dest, src_data}),
      .raddr (rd_ptr_q),
      .rdata (rd_entry)
   );

   assign {dest_addr, data_in} = rd_entry;

endmodule

// File: tb/tb_router_ingress_fifo.sv
// Scoreboard bench for router_ingress_fifo: stimulus queues accepted entries, a monitor checks pops.
module tb_router_ingress_fifo;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic       src_valid = 1'b0;
   logic [7:0] src_data = '0;
   logic [1:0] src_dest = '0;
   logic       src_ready;
   logic       pkt_valid;
   logic [7:0] data_in;
   logic [1:0] dest_addr;
   logic       ready_in = 1'b0;
   logic [3:0] count;
   logic       full;
   logic       empty;

   int         n_cmp = 0;
   int         n_err = 0;
   int         m_count = 0;
   bit         mon_en = 1'b0;
   logic [9:0] exp_q [$];

   router_ingress_fifo #(.DEPTH(DEPTH), .DATA_W(8), .ADDR_W(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .src_valid (src_valid),
      .src_data  (src_data),
      .src_dest  (src_dest),
      .src_ready (src_ready),
      .pkt_valid (pkt_valid),
      .data_in   (data_in),
      .dest_addr (dest_addr),
      .ready_in  (ready_in),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: whatever the DUT hands to the router must match the scoreboard head.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("pkt_valid", pkt_valid, (m_count != 0));
         if (pkt_valid === 1'b1 && ready_in && !rst && !flush) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_pop: got %0h expected none", {dest_addr, data_in});
            end else begin
               chk("head", {dest_addr, data_in}, exp_q.pop_front());
            end
         end
      end
   end

   task automatic cycle(input bit sv, input logic [7:0] d, input logic [1:0] ds,
                        input bit rdy, input bit fl, input bit rs);
      bit push_e, pop_e;
      src_valid = sv;
      src_data  = d;
      src_dest  = ds;
      ready_in  = rdy;
      flush     = fl;
      rst       = rs;
      @(negedge clk);
      push_e = sv && (m_count < DEPTH);
      pop_e  = rdy && (m_count > 0);
      @(posedge clk);
      #1;
      if (rs || fl) begin
         exp_q.delete();
         m_count = 0;
      end else begin
         if (push_e) exp_q.push_back({ds, d});
         m_count = m_count + int'(push_e) - int'(pop_e);
      end
      if (mon_en) begin
         chk("count", count, m_count);
         chk("full", full, (m_count == DEPTH));
         chk("empty", empty, (m_count == 0));
         chk("src_ready", src_ready, (m_count != DEPTH));
      end
   endtask

   task automatic idle(input bit rdy, input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 2'd0, rdy, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset held 2 cycles while the source offers data
      cycle(1'b1, 8'h55, 2'd1, 1'b0, 1'b0, 1'b1);
      mon_en = 1'b1;
      cycle(1'b1, 8'h55, 2'd1, 1'b0, 1'b0, 1'b1);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_pkt_valid", pkt_valid, 0);
      chk("rst_src_ready", src_ready, 1);
      idle(1'b0, 1);
      chk("rst_nothing_stored", pkt_valid, 0);

      // Single pass-through
      cycle(1'b1, 8'hAA, 2'd0, 1'b1, 1'b0, 1'b0);
      chk("pt_valid", pkt_valid, 1);
      chk("pt_data", data_in, 8'hAA);
      chk("pt_dest", dest_addr, 0);
      idle(1'b1, 1);
      chk("pt_empty_after", empty, 1);

      // Stall then release
      cycle(1'b1, 8'hBB, 2'd1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hCC, 2'd2, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'hDD, 2'd3, 1'b0, 1'b0, 1'b0);
      chk("stall_count", count, 3);
      chk("stall_head", data_in, 8'hBB);
      idle(1'b0, 2);
      chk("stall_hold_data", data_in, 8'hBB);
      chk("stall_hold_dest", dest_addr, 1);
      idle(1'b1, 3);
      chk("stall_drained", empty, 1);

      // Full, overflow attempt, wrap-around
      for (int i = 0; i < 8; i++) cycle(1'b1, 8'h10 + 8'(i), 2'(i), 1'b0, 1'b0, 1'b0);
      chk("full_flag", full, 1);
      chk("full_src_ready", src_ready, 0);
      cycle(1'b1, 8'hFF, 2'd3, 1'b0, 1'b0, 1'b0);
      chk("overflow_count", count, 8);
      idle(1'b1, 3);
      chk("after_pop3", count, 5);
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'h18 + 8'(i), 2'(i), 1'b0, 1'b0, 1'b0);
      chk("wrap_count", count, 8);
      idle(1'b1, 8);
      chk("wrap_drained", empty, 1);

      // Simultaneous push/pop at count 4 and at count 8
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'h20 + 8'(i), 2'(i), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h24, 2'd0, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 8'h25, 2'd1, 1'b1, 1'b0, 1'b0);
      chk("pp4_count", count, 4);
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'h26 + 8'(i), 2'(i), 1'b0, 1'b0, 1'b0);
      chk("pp8_full", full, 1);
      cycle(1'b1, 8'hEE, 2'd2, 1'b1, 1'b0, 1'b0);
      chk("pp8_count", count, 7);
      idle(1'b1, 7);
      chk("pp_drained", empty, 1);

      // Flush with a concurrent push at count 5
      for (int i = 0; i < 5; i++) cycle(1'b1, 8'h30 + 8'(i), 2'(i), 1'b0, 1'b0, 1'b0);
      chk("pre_flush_count", count, 5);
      cycle(1'b1, 8'h77, 2'd1, 1'b0, 1'b1, 1'b0);
      chk("flush_count", count, 0);
      chk("flush_pkt_valid", pkt_valid, 0);
      cycle(1'b1, 8'h5A, 2'd2, 1'b0, 1'b0, 1'b0);
      chk("post_flush_data", data_in, 8'h5A);
      chk("post_flush_dest", dest_addr, 2);
      idle(1'b1, 1);

      // Reset mid-packet drops everything
      cycle(1'b1, 8'h41, 2'd1, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h42, 2'd2, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 8'h43, 2'd3, 1'b1, 1'b0, 1'b1);
      chk("midrst_pkt_valid", pkt_valid, 0);
      chk("midrst_count", count, 0);
      idle(1'b1, 2);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
